// File: rtl/mc_issue_ctrl_pkg.sv
// Shared definitions for the multi-cycle issue controller:
// op select encodings and controller state encodings.
package mc_issue_ctrl_pkg;

    localparam logic [1:0] OP_CLZ  = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_DIVU = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    function automatic logic op_ok(input logic [1:0] sel);
        return sel != OP_RSVD;
    endfunction

endpackage

// File: rtl/mc_issue_ctrl_if.sv
// Bus between decode, the iterative units and the issue controller.
// master = decode/units side, slave = the controller.
interface mc_issue_ctrl_if;

    logic        op_valid;
    logic [1:0]  op_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rd_addr;
    logic        stall;

    logic        clz_start;
    logic [31:0] clz_in;
    logic        clz_busy;
    logic [31:0] clz_result;

    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_busy;
    logic [31:0] div_q;
    logic [31:0] div_r;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        err;

    modport master (
        output op_valid, op_sel, rs_data, rt_data, rd_addr,
        output clz_busy, clz_result,
        output div_busy, div_q, div_r,
        input  stall, clz_start, clz_in,
        input  div_start, div_signed, div_a, div_b,
        input  rf_we, rf_waddr, rf_wdata,
        input  hilo_we, hi_wdata, lo_wdata, err
    );

    modport slave (
        input  op_valid, op_sel, rs_data, rt_data, rd_addr,
        input  clz_busy, clz_result,
        input  div_busy, div_q, div_r,
        output stall, clz_start, clz_in,
        output div_start, div_signed, div_a, div_b,
        output rf_we, rf_waddr, rf_wdata,
        output hilo_we, hi_wdata, lo_wdata, err
    );

endinterface

// File: rtl/mc_watchdog.sv
// RUN-cycle watchdog: counts busy cycles of the active unit and
// flags the cycle whose increment would bring the count to TIMEOUT.
module mc_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // busy-cycle counter, cleared while the unit is being armed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = en & (cnt == LAST);

endmodule

// File: rtl/mc_issue_ctrl.sv
// Issue/writeback controller for the iterative CLZ and divide units.
// Launches one op, stalls decode while the unit runs, then writes back.
module mc_issue_ctrl
    import mc_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic           clk,
    input  logic           reset,
    mc_issue_ctrl_if.slave bus
);

    state_t      state;
    logic [1:0]  sel;
    logic [4:0]  rd;

    logic        clz_start;
    logic [31:0] clz_in;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        err;

    logic        accept;
    logic        unit_busy;
    logic        wd_clr;
    logic        wd_en;
    logic        wd_hit;

    assign accept    = (state == S_IDLE) & bus.op_valid & op_ok(bus.op_sel);
    assign unit_busy = (sel == OP_CLZ) ? bus.clz_busy : bus.div_busy;
    assign wd_clr    = (state == S_ARM);
    assign wd_en     = (state == S_RUN) & unit_busy;

    mc_watchdog #(
        .TIMEOUT(TIMEOUT),
        .CW     (CW)
    ) u_watchdog (
        .clk  (clk),
        .reset(reset),
        .clr  (wd_clr),
        .en   (wd_en),
        .hit  (wd_hit)
    );

    // issue FSM: latch op, pulse start, wait on busy, write back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sel        <= OP_CLZ;
            rd         <= '0;
            clz_start  <= 1'b0;
            clz_in     <= '0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            hilo_we    <= 1'b0;
            hi_wdata   <= '0;
            lo_wdata   <= '0;
            err        <= 1'b0;
        end else begin
            clz_start <= 1'b0;
            div_start <= 1'b0;
            rf_we     <= 1'b0;
            hilo_we   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        sel <= bus.op_sel;
                        rd  <= bus.rd_addr;
                        if (bus.op_sel == OP_CLZ) begin
                            clz_in    <= bus.rs_data;
                            clz_start <= 1'b1;
                        end else begin
                            div_a      <= bus.rs_data;
                            div_b      <= bus.rt_data;
                            div_signed <= (bus.op_sel == OP_DIV);
                            div_start  <= 1'b1;
                        end
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (!unit_busy) begin
                        if (sel == OP_CLZ) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= bus.clz_result;
                        end else begin
                            hilo_we  <= 1'b1;
                            hi_wdata <= bus.div_r;
                            lo_wdata <= bus.div_q;
                        end
                        state <= S_WB;
                    end else if (wd_hit) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall      = accept | (state == S_ARM) | (state == S_RUN);
    assign bus.clz_start  = clz_start;
    assign bus.clz_in     = clz_in;
    assign bus.div_start  = div_start;
    assign bus.div_signed = div_signed;
    assign bus.div_a      = div_a;
    assign bus.div_b      = div_b;
    assign bus.rf_we      = rf_we;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.hilo_we    = hilo_we;
    assign bus.hi_wdata   = hi_wdata;
    assign bus.lo_wdata   = lo_wdata;
    assign bus.err        = err;

endmodule

// File: tb/tb_mc_issue_ctrl.sv
// Bench for mc_issue_ctrl: behavioural CLZ/divider stubs, a
// transaction-level timing model and directed literal checks.
module tb_mc_issue_ctrl;

    localparam int TIMEOUT = 64;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    mc_issue_ctrl_if bus ();

    mc_issue_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CW     (7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h expected %h at cycle %0d",
                         name, act, exp, cyc);
        end
    endtask

    function automatic int clz_ref(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 31; i >= 0 && !v[i]; i--) n++;
        return n;
    endfunction

    // returns {remainder, quotient}
    function automatic logic [63:0] div_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // ---------------- behavioural units ----------------
    int          clz_rem;
    logic [31:0] clz_res;
    int          div_rem;
    logic [63:0] div_res;
    logic        div_stuck = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            clz_rem <= 0;
            clz_res <= '0;
        end else if (bus.clz_start) begin
            clz_rem <= clz_ref(bus.clz_in) + 1;
            clz_res <= 32'(clz_ref(bus.clz_in));
        end else if (clz_rem > 0) begin
            clz_rem <= clz_rem - 1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div_rem <= 0;
            div_res <= '0;
        end else if (bus.div_start) begin
            div_rem <= DIV_LAT;
            div_res <= div_ref(bus.div_a, bus.div_b, bus.div_signed);
        end else if (div_rem > 0) begin
            div_rem <= div_rem - 1;
        end
    end

    assign bus.clz_busy   = (clz_rem != 0);
    assign bus.clz_result = bus.clz_busy ? 32'hDEAD_BEEF : clz_res;
    assign bus.div_busy   = div_stuck | (div_rem != 0);
    assign bus.div_q      = bus.div_busy ? 32'hBAD0_0000 : div_res[31:0];
    assign bus.div_r      = bus.div_busy ? 32'hBAD0_0001 : div_res[63:32];

    // ---------------- transaction model + compare ----------------
    int          free_at = 0;
    int          stall_last = -1;
    int          start_cyc = -1;
    int          wr_cyc = -1;
    int          err_cyc = -1;
    int          m_lat;
    logic [1:0]  m_sel = 2'd0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_d;

    int          rf_count = 0;
    int          hilo_count = 0;
    int          clz_start_count = 0;
    int          last_rf_cyc = -1;
    int          last_clz_start_cyc = -1;
    logic [4:0]  last_rf_addr = '0;
    logic [31:0] last_rf_data = '0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always @(negedge clk) begin
        if (reset) begin
            free_at    = 0;
            stall_last = -1;
            start_cyc  = -1;
            wr_cyc     = -1;
            err_cyc    = -1;
        end else begin
            if (bus.op_valid && bus.op_sel != 2'd3 && cyc >= free_at) begin
                m_sel = bus.op_sel;
                m_a   = bus.rs_data;
                m_b   = bus.rt_data;
                m_rd  = bus.rd_addr;
                start_cyc = cyc + 1;
                if (m_sel == 2'd0) begin
                    m_lat = clz_ref(m_a) + 1;
                    m_wd  = 32'(clz_ref(m_a));
                end else begin
                    m_lat = div_stuck ? 1000 : DIV_LAT;
                    m_d   = div_ref(m_a, m_b, m_sel == 2'd1);
                    m_hi  = m_d[63:32];
                    m_lo  = m_d[31:0];
                end
                if (m_lat < TIMEOUT) begin
                    wr_cyc     = cyc + m_lat + 3;
                    stall_last = cyc + m_lat + 2;
                    free_at    = cyc + m_lat + 4;
                end else begin
                    wr_cyc     = -1;
                    stall_last = cyc + TIMEOUT + 1;
                    free_at    = cyc + TIMEOUT + 2;
                    if (err_cyc < 0) err_cyc = free_at;
                end
            end

            chk("stall", 32'(bus.stall), 32'(cyc <= stall_last));
            chk("clz_start", 32'(bus.clz_start),
                32'(cyc == start_cyc && m_sel == 2'd0));
            chk("div_start", 32'(bus.div_start),
                32'(cyc == start_cyc && m_sel != 2'd0));
            if (cyc == start_cyc) begin
                if (m_sel == 2'd0) begin
                    chk("clz_in", bus.clz_in, m_a);
                end else begin
                    chk("div_a", bus.div_a, m_a);
                    chk("div_b", bus.div_b, m_b);
                    chk("div_signed", 32'(bus.div_signed),
                        32'(m_sel == 2'd1));
                end
            end
            chk("rf_we", 32'(bus.rf_we),
                32'(cyc == wr_cyc && m_sel == 2'd0));
            chk("hilo_we", 32'(bus.hilo_we),
                32'(cyc == wr_cyc && m_sel != 2'd0));
            if (cyc == wr_cyc && m_sel == 2'd0) begin
                chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_rd));
                chk("rf_wdata", bus.rf_wdata, m_wd);
            end
            if (cyc == wr_cyc && m_sel != 2'd0) begin
                chk("hi_wdata", bus.hi_wdata, m_hi);
                chk("lo_wdata", bus.lo_wdata, m_lo);
            end
            chk("err", 32'(bus.err), 32'(err_cyc >= 0 && cyc >= err_cyc));

            if (bus.rf_we) begin
                rf_count++;
                last_rf_cyc  = cyc;
                last_rf_addr = bus.rf_waddr;
                last_rf_data = bus.rf_wdata;
            end
            if (bus.hilo_we) begin
                hilo_count++;
                last_hi = bus.hi_wdata;
                last_lo = bus.lo_wdata;
            end
            if (bus.clz_start) begin
                clz_start_count++;
                last_clz_start_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input bit hold, output int c0, output int hi_n);
        int n;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op_sel   = sel;
        bus.rs_data  = a;
        bus.rt_data  = b;
        bus.rd_addr  = rd;
        c0 = cyc;
        n  = 0;
        if (hold) begin
            @(negedge clk);
            while (bus.stall && n < 300) begin
                n++;
                @(negedge clk);
            end
            if (n >= 300) chk("stall_timeout", 32'(n), 32'(0));
        end
        hi_n = n;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op_sel   = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c0;
    int hn;
    int rf0;
    int hl0;
    int cs0;
    int ce;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.op_valid = 1'b0;
        bus.op_sel   = 2'd0;
        bus.rs_data  = '0;
        bus.rt_data  = '0;
        bus.rd_addr  = '0;

        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_clz_start", 32'(bus.clz_start), 0);
        chk("rst_div_start", 32'(bus.div_start), 0);
        chk("rst_rf_we", 32'(bus.rf_we), 0);
        chk("rst_hilo_we", 32'(bus.hilo_we), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_clz_in", bus.clz_in, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // CLZ of 0x8000_0000: start in cycle 1, write in cycle 4
        cs0 = clz_start_count;
        issue(2'd0, 32'h8000_0000, 0, 5'd5, 1'b1, c0, hn);
        chk("t1_start_cyc", 32'(last_clz_start_cyc - c0), 1);
        chk("t1_start_cnt", 32'(clz_start_count - cs0), 1);
        chk("t1_wr_cyc", 32'(last_rf_cyc - c0), 4);
        chk("t1_waddr", 32'(last_rf_addr), 5);
        chk("t1_wdata", last_rf_data, 0);
        chk("t1_stall_cycles", 32'(hn), 4);

        issue(2'd0, 32'h0000_0001, 0, 5'd9, 1'b1, c0, hn);
        chk("t2_wr_cyc", 32'(last_rf_cyc - c0), 35);
        chk("t2_waddr", 32'(last_rf_addr), 9);
        chk("t2_wdata", last_rf_data, 31);

        issue(2'd0, 32'h0000_0000, 0, 5'd3, 1'b1, c0, hn);
        chk("t3_wr_cyc", 32'(last_rf_cyc - c0), 36);
        chk("t3_wdata", last_rf_data, 32);

        // DIVU 100/7 goes to HI/LO only
        rf0 = rf_count;
        hl0 = hilo_count;
        issue(2'd2, 32'd100, 32'd7, 5'd4, 1'b1, c0, hn);
        idle(2);
        chk("t4_hilo_cnt", 32'(hilo_count - hl0), 1);
        chk("t4_lo", last_lo, 14);
        chk("t4_hi", last_hi, 2);
        chk("t4_rf_cnt", 32'(rf_count - rf0), 0);

        // reset while a long CLZ is running
        rf0 = rf_count;
        issue(2'd0, 32'h0000_0000, 0, 5'd7, 1'b0, c0, hn);
        idle(10);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_stall", 32'(bus.stall), 0);
        chk("t5_rf_we", 32'(bus.rf_we), 0);
        chk("t5_clz_start", 32'(bus.clz_start), 0);
        chk("t5_clz_in", bus.clz_in, 0);
        chk("t5_rf_wdata", bus.rf_wdata, 0);
        chk("t5_rf_waddr", 32'(bus.rf_waddr), 0);
        chk("t5_lo", bus.lo_wdata, 0);
        idle(2);
        reset = 1'b0;
        idle(40);
        chk("t5_no_write", 32'(rf_count - rf0), 0);
        issue(2'd0, 32'h00F0_0000, 0, 5'd12, 1'b1, c0, hn);
        chk("t5_wdata", last_rf_data, 8);
        chk("t5_waddr", 32'(last_rf_addr), 12);

        // divider busy stuck high: watchdog abort
        hl0 = hilo_count;
        div_stuck = 1'b1;
        issue(2'd1, 32'd50, 32'd5, 5'd0, 1'b0, c0, hn);
        ce = -1;
        for (int i = 0; i < 200 && ce < 0; i++) begin
            @(negedge clk);
            if (bus.err) begin
                ce = cyc;
                chk("t6_stall_low", 32'(bus.stall), 0);
            end
        end
        chk("t6_err_cyc", 32'(ce - c0), TIMEOUT + 2);
        chk("t6_no_write", 32'(hilo_count - hl0), 0);
        div_stuck = 1'b0;
        idle(2);
        issue(2'd0, 32'h0000_FFFF, 0, 5'd21, 1'b1, c0, hn);
        chk("t6_wdata", last_rf_data, 16);
        chk("t6_wr_cyc", 32'(last_rf_cyc - c0), 20);
        chk("t6_err_sticky", 32'(bus.err), 1);

        // random traffic checked by the model
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  s;
            logic [31:0] a;
            logic [31:0] b;
            s = 2'($urandom_range(0, 3));
            a = $urandom >> $urandom_range(0, 32);
            if ($urandom_range(0, 4) == 0) b = 32'd0;
            else b = $urandom >> $urandom_range(0, 31);
            issue(s, a, b, 5'($urandom), 1'($urandom_range(0, 1)), c0, hn);
            idle($urandom_range(0, 3));
        end
        idle(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
